// File: rtl/wall_collision_ctrl.sv
// Game controller beside the vertical-wall stages: sequences load/ready/play/crash,
// detects cube/wall overlap per frame and keeps a saturating frame-survival score.
module wall_collision_ctrl #(
  parameter int unsigned NWALL        = 7,
  parameter int unsigned HIT_THRESH   = 4,
  parameter int unsigned SCORE_DIV    = 60,
  parameter int unsigned FLASH_FRAMES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame,
  input  logic             btnC,
  input  logic             btnU,
  input  logic             cube_px,
  input  logic [NWALL-1:0] wall_px,
  output logic             load_counter,
  output logic             start_machine,
  output logic             stop,
  output logic             flash,
  output logic             crash,
  output logic [15:0]      score,
  output logic [NWALL-1:0] wall_hit
);

  localparam int unsigned DivW   = $clog2(SCORE_DIV + 1);
  localparam int unsigned FlashW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StReady = 2'd1,
    StPlay  = 2'd2,
    StCrash = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               frame_q;
  logic               load_tick_q, load_tick_d;
  logic [7:0]         ovl_cnt_q, ovl_cnt_d;
  logic [DivW-1:0]    div_cnt_q, div_cnt_d;
  logic [FlashW-1:0]  flash_cnt_q, flash_cnt_d;
  logic               load_counter_q, load_counter_d;
  logic               start_machine_q, start_machine_d;
  logic               stop_q, stop_d;
  logic               flash_q, flash_d;
  logic               crash_q, crash_d;
  logic [15:0]        score_q, score_d;
  logic [NWALL-1:0]   wall_hit_q, wall_hit_d;

  logic       frame_tick;
  logic       hit;
  logic [8:0] ovl_sum;
  logic       crash_now;
  logic       restart;

  assign frame_tick = frame & ~frame_q;
  assign hit        = cube_px & (|wall_px);
  // The decision on a frame tick must include an overlap on that very cycle.
  assign ovl_sum    = {1'b0, ovl_cnt_q} + {8'd0, hit};
  assign crash_now  = ovl_sum >= 9'(HIT_THRESH);
  assign restart    = btnU & ((state_q == StPlay) | (state_q == StCrash));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StLoad;
      frame_q         <= 1'b0;
      load_tick_q     <= 1'b0;
      ovl_cnt_q       <= '0;
      div_cnt_q       <= '0;
      flash_cnt_q     <= '0;
      load_counter_q  <= 1'b1;
      start_machine_q <= 1'b0;
      stop_q          <= 1'b0;
      flash_q         <= 1'b1;
      crash_q         <= 1'b0;
      score_q         <= '0;
      wall_hit_q      <= '0;
    end else begin
      state_q         <= state_d;
      frame_q         <= frame;
      load_tick_q     <= load_tick_d;
      ovl_cnt_q       <= ovl_cnt_d;
      div_cnt_q       <= div_cnt_d;
      flash_cnt_q     <= flash_cnt_d;
      load_counter_q  <= load_counter_d;
      start_machine_q <= start_machine_d;
      stop_q          <= stop_d;
      flash_q         <= flash_d;
      crash_q         <= crash_d;
      score_q         <= score_d;
      wall_hit_q      <= wall_hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad:  if (frame_tick && load_tick_q) state_d = StReady;
      StReady: if (btnC) state_d = StPlay;
      StPlay: begin
        if (btnU) state_d = StLoad;
        else if (frame_tick && crash_now) state_d = StCrash;
      end
      StCrash: if (btnU) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    load_tick_d = load_tick_q;
    ovl_cnt_d   = ovl_cnt_q;
    div_cnt_d   = div_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    crash_d     = crash_q;
    score_d     = score_q;
    wall_hit_d  = wall_hit_q;

    if (state_q == StLoad && frame_tick) load_tick_d = ~load_tick_q;

    if (frame_tick) ovl_cnt_d = '0;
    else if (state_q == StPlay && hit && ovl_cnt_q != 8'hFF) ovl_cnt_d = ovl_cnt_q + 8'd1;

    if (state_q == StPlay && hit) wall_hit_d = wall_hit_q | wall_px;

    if (state_q == StPlay && frame_tick) begin
      if (crash_now) begin
        crash_d     = 1'b1;
        flash_cnt_d = '0;
        flash_d     = 1'b1;
      end else if (div_cnt_q == DivW'(SCORE_DIV - 1)) begin
        div_cnt_d = '0;
        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end

    if (state_q == StCrash && frame_tick) begin
      if (flash_cnt_q == FlashW'(FLASH_FRAMES - 1)) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FlashW'(1);
      end
    end

    // Restart overrides everything, including a coincident frame tick.
    if (restart) begin
      load_tick_d = 1'b0;
      ovl_cnt_d   = '0;
      div_cnt_d   = '0;
      flash_cnt_d = '0;
      flash_d     = 1'b1;
      crash_d     = 1'b0;
      score_d     = '0;
      wall_hit_d  = '0;
    end

    load_counter_d  = (state_d == StLoad);
    start_machine_d = (state_d == StPlay);
    stop_d          = (state_d == StPlay);
  end

  assign load_counter  = load_counter_q;
  assign start_machine = start_machine_q;
  assign stop          = stop_q;
  assign flash         = flash_q;
  assign crash         = crash_q;
  assign score         = score_q;
  assign wall_hit      = wall_hit_q;

endmodule
